// File: rtl/sram_pkg.sv
// sram_pkg
// Shared definitions for the 1R1W pipelined SRAM array.
//   addr_width()     : address width for a given depth, never below 1 bit
//   sram_state_e     : sweep/operate controller states
//   mask_merge_bit() : one bit of a masked write/bypass merge
package sram_pkg;

    // INIT: zero-fill sweep running, requests ignored.
    // IDLE: normal operation.
    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } sram_state_e;

    // max(1, clog2(depth)); a 1-word or 2-word array still needs one address bit.
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // A bit takes the new value only when its segment's mask bit is set.
    // Used both for the array write and for the same-cycle bypass view.
    function automatic logic mask_merge_bit(input logic old_bit,
                                            input logic new_bit,
                                            input logic seg_en);
        return seg_en ? new_bit : old_bit;
    endfunction

endpackage

// File: rtl/sram_rdpipe.sv
// sram_rdpipe
// LATENCY-deep valid/data pipeline for the SRAM read port.
// Data registers only load when their incoming valid is set, so the output
// holds the last delivered word while out_valid is low.
// Ports:
//   clk       in   clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset; flushes valids, zeroes data
//   in_valid  in   read accepted this cycle
//   in_data   in   word sampled from the array this cycle
//   out_valid out  delivered read, LATENCY cycles after in_valid
//   out_data  out  delivered word, held between deliveries
module sram_rdpipe #(
    parameter int WIDTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   dat_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/sram_array_1r1w_pipe.sv
// sram_array_1r1w_pipe
// One-read one-write SRAM array with per-segment write mask, optional
// same-cycle write->read bypass, a pipelined read port and an optional
// zero-fill sweep after reset.
// Ports:
//   R0_clk    in   sole clock
//   rst_n     in   asynchronous active-low reset
//   R0_addr   in   read address (ADDR_W)
//   R0_en     in   read request
//   R0_data   out  read data (WIDTH), held when no read is delivered
//   R0_valid  out  R0_data carries a read result
//   W0_addr   in   write address (ADDR_W)
//   W0_en     in   write request
//   W0_data   in   write data (WIDTH)
//   W0_mask   in   per-segment write enable (MASK_SEG)
//   init_busy out  zero-fill sweep in progress
//   dbg_state out  controller state (0 = INIT, 1 = IDLE)
//
// Request semantics: there is no ready. While init_busy is low every cycle
// with R0_en=1 is an accepted read and produces exactly one R0_valid pulse
// READ_LATENCY cycles later; every cycle with W0_en=1 is an accepted write.
// While init_busy is high both requests are dropped.
module sram_array_1r1w_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int WIDTH         = 256,
    parameter int MASK_GRAN     = 64,
    parameter int READ_LATENCY  = 1,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1,
    localparam int ADDR_W       = addr_width(DEPTH),
    localparam int MASK_SEG     = WIDTH / MASK_GRAN
) (
    input  logic                R0_clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   R0_addr,
    input  logic                R0_en,
    output logic [WIDTH-1:0]    R0_data,
    output logic                R0_valid,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic                W0_en,
    input  logic [WIDTH-1:0]    W0_data,
    input  logic [MASK_SEG-1:0] W0_mask,
    output logic                init_busy,
    output logic                dbg_state
);

    localparam sram_state_e      RESET_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Controller: sweep pointer walks 0..DEPTH-1, one word per cycle.
    // ------------------------------------------------------------------
    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge R0_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_busy = 1'b0;
        case (state_q)
            INIT: begin
                init_busy = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RESET_STATE;
                ptr_d   = '0;
            end
        endcase
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Request decode. Addresses past the last word are legal inputs:
    // writes to them are dropped, reads of them return zero.
    // ------------------------------------------------------------------
    logic rd_in_range, wr_in_range;
    logic rd_fire, wr_fire;

    assign rd_in_range = (32'(R0_addr) < DEPTH);
    assign wr_in_range = (32'(W0_addr) < DEPTH);
    assign rd_fire     = R0_en && (state_q == IDLE);
    assign wr_fire     = W0_en && (state_q == IDLE) && wr_in_range;

    // ------------------------------------------------------------------
    // Storage. No reset here: contents survive reset and are only cleared
    // by the sweep.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge R0_clk) begin
        if (state_q == INIT) begin
            mem[ptr_q] <= '0;
        end else if (wr_fire) begin
            for (int s = 0; s < MASK_SEG; s++) begin
                if (W0_mask[s]) begin
                    mem[W0_addr][s*MASK_GRAN +: MASK_GRAN] <= W0_data[s*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read sample. The word is captured in the request cycle, so later
    // writes cannot reach a read already in the pipeline. With BYPASS the
    // captured word already reflects a same-cycle write to the same word.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] rd_word;

    assign rd_old = rd_in_range ? mem[R0_addr] : '0;

    always_comb begin
        rd_word = rd_old;
        // wr_fire implies W0_addr is in range, so a match implies the read is too.
        if ((BYPASS != 0) && wr_fire && (W0_addr == R0_addr)) begin
            for (int b = 0; b < WIDTH; b++) begin
                rd_word[b] = mask_merge_bit(rd_old[b], W0_data[b], W0_mask[b / MASK_GRAN]);
            end
        end
    end

    sram_rdpipe #(
        .WIDTH   (WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk       (R0_clk),
        .rst_n     (rst_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (R0_valid),
        .out_data  (R0_data)
    );

endmodule

// File: tb/tb_sram_array_1r1w_pipe.sv
// tb_sram_array_1r1w_pipe
// Two instances share one stimulus stream:
//   dut_a: DEPTH=64, READ_LATENCY=2, BYPASS=1
//   dut_b: DEPTH=48, READ_LATENCY=1, BYPASS=0
// Both use WIDTH=256, MASK_GRAN=64 (4 segments), INIT_ON_RESET=1, so the
// address width is 6 bits for both and addresses 48..63 are out of range
// for dut_b only. Each instance has its own reference array, expected queue
// and monitor.
module tb_sram_array_1r1w_pipe;

    localparam int W = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [5:0]   R0_addr, W0_addr;
    logic         R0_en, W0_en;
    logic [W-1:0] W0_data;
    logic [3:0]   W0_mask;

    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid, a_busy, b_busy, a_state, b_state;

    sram_array_1r1w_pipe #(
        .DEPTH(64), .WIDTH(256), .MASK_GRAN(64),
        .READ_LATENCY(2), .BYPASS(1), .INIT_ON_RESET(1)
    ) dut_a (
        .R0_clk(clk), .rst_n(rst_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(a_data), .R0_valid(a_valid),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_busy(a_busy), .dbg_state(a_state)
    );

    sram_array_1r1w_pipe #(
        .DEPTH(48), .WIDTH(256), .MASK_GRAN(64),
        .READ_LATENCY(1), .BYPASS(0), .INIT_ON_RESET(1)
    ) dut_b (
        .R0_clk(clk), .rst_n(rst_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(b_data), .R0_valid(b_valid),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_busy(b_busy), .dbg_state(b_state)
    );

    // ---------------- scoreboard state ----------------
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic         mon_en    = 1'b0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    int           due_q_a[$];
    int           due_q_b[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;

    // Reference arrays: index 0 models dut_a, index 1 models dut_b.
    logic [W-1:0] mdl [2][64];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int depth_of(input int k);
        return (k == 0) ? 64 : 48;
    endfunction

    function automatic logic [W-1:0] model_read(input int k, input logic [5:0] ra,
                                                input logic wen, input logic [5:0] wa,
                                                input logic [W-1:0] wd, input logic [3:0] wm);
        logic [W-1:0] r;
        if (int'(ra) >= depth_of(k)) return '0;
        r = mdl[k][ra];
        // Only dut_a forwards a same-cycle write into the read result.
        if (k == 0 && wen && wa == ra) begin
            for (int s = 0; s < 4; s++) begin
                if (wm[s]) r[s*64 +: 64] = wd[s*64 +: 64];
            end
        end
        return r;
    endfunction

    function automatic void model_write(input int k, input logic [5:0] wa,
                                        input logic [W-1:0] wd, input logic [3:0] wm);
        if (int'(wa) < depth_of(k)) begin
            for (int s = 0; s < 4; s++) begin
                if (wm[s]) mdl[k][wa][s*64 +: 64] = wd[s*64 +: 64];
            end
        end
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                mdl[k][i] = '0;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        R0_en = 1'b0; R0_addr = '0;
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
    endtask

    task automatic drive(input logic ren, input logic [5:0] ra, input logic wen,
                         input logic [5:0] wa, input logic [W-1:0] wd, input logic [3:0] wm);
        @(negedge clk);
        R0_en = ren; R0_addr = ra;
        W0_en = wen; W0_addr = wa; W0_data = wd; W0_mask = wm;
        if (ren) begin
            exp_q_a.push_back(model_read(0, ra, wen, wa, wd, wm));
            due_q_a.push_back(cyc + 2);
            exp_q_b.push_back(model_read(1, ra, wen, wa, wd, wm));
            due_q_b.push_back(cyc + 1);
        end
        if (wen) begin
            model_write(0, wa, wd, wm);
            model_write(1, wa, wd, wm);
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic flush_sb();
        exp_q_a.delete(); due_q_a.delete(); last_a = '0;
        exp_q_b.delete(); due_q_b.delete(); last_b = '0;
    endtask

    // Counts the busy cycles of each instance from reset release. With poke
    // set, random requests are thrown at both instances while both sweep;
    // they must be ignored.
    task automatic measure_init(input logic poke);
        int na;
        int nb;
        na = 0;
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            if (!a_busy && !b_busy) break;
            if (a_busy) na++;
            if (b_busy) nb++;
            if (poke && a_busy && b_busy) begin
                R0_en   = 1'($urandom_range(0, 1));
                R0_addr = 6'($urandom_range(0, 63));
                W0_en   = 1'($urandom_range(0, 1));
                W0_addr = 6'($urandom_range(0, 63));
                W0_data = rand_word() | W'(1);
                W0_mask = 4'($urandom_range(1, 15));
            end else begin
                set_idle();
            end
            @(negedge clk);
        end
        chk("a_init_cycles", W'(na), W'(64));
        chk("b_init_cycles", W'(nb), W'(48));
        set_idle();
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_busy) chk("a_valid_during_init", W'(a_valid), '0);
            if (a_valid) begin
                if (exp_q_a.size() == 0) chk("a_spurious_valid", W'(a_valid), '0);
                else begin
                    chk("a_rdata", a_data, exp_q_a[0]);
                    chk("a_latency", W'(cyc), W'(due_q_a[0]));
                    last_a = exp_q_a.pop_front();
                    void'(due_q_a.pop_front());
                end
            end else begin
                chk("a_hold", a_data, last_a);
                if (due_q_a.size() > 0 && due_q_a[0] <= cyc) begin
                    chk("a_missing_valid", W'(a_valid), W'(1'b1));
                    void'(exp_q_a.pop_front());
                    void'(due_q_a.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_busy) chk("b_valid_during_init", W'(b_valid), '0);
            if (b_valid) begin
                if (exp_q_b.size() == 0) chk("b_spurious_valid", W'(b_valid), '0);
                else begin
                    chk("b_rdata", b_data, exp_q_b[0]);
                    chk("b_latency", W'(cyc), W'(due_q_b[0]));
                    last_b = exp_q_b.pop_front();
                    void'(due_q_b.pop_front());
                end
            end else begin
                chk("b_hold", b_data, last_b);
                if (due_q_b.size() > 0 && due_q_b[0] <= cyc) begin
                    chk("b_missing_valid", W'(b_valid), W'(1'b1));
                    void'(exp_q_b.pop_front());
                    void'(due_q_b.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ra;
        logic [5:0] wa;

        rst_n = 1'b0;
        set_idle();
        clear_model();
        repeat (3) @(negedge clk);

        // Reset state.
        chk("a_reset_valid", W'(a_valid), '0);
        chk("a_reset_data",  a_data, '0);
        chk("a_reset_busy",  W'(a_busy), W'(1'b1));
        chk("a_reset_state", W'(a_state), '0);
        chk("b_reset_valid", W'(b_valid), '0);
        chk("b_reset_data",  b_data, '0);
        chk("b_reset_busy",  W'(b_busy), W'(1'b1));
        chk("b_reset_state", W'(b_state), '0);
        mon_en = 1'b1;

        // Sweep lengths, with requests thrown at both instances meanwhile.
        rst_n = 1'b1;
        measure_init(1'b1);
        clear_model();

        // Last word after the sweep (out of range for dut_b).
        drive(1'b1, 6'd63, 1'b0, '0, '0, '0);

        // Full write then read of address 5.
        drive(1'b0, '0, 1'b1, 6'd5, {32{8'hA5}}, 4'hF);
        drive(1'b1, 6'd5, 1'b0, '0, '0, '0);

        // Address 7: all ones, then masked zero write with same-cycle read.
        drive(1'b0, '0, 1'b1, 6'd7, '1, 4'hF);
        drive(1'b1, 6'd7, 1'b1, 6'd7, '0, 4'b0101);
        drive(1'b1, 6'd7, 1'b0, '0, '0, '0);

        // Empty mask with same-cycle read.
        drive(1'b1, 6'd7, 1'b1, 6'd7, rand_word(), 4'b0000);
        drive(1'b1, 6'd7, 1'b0, '0, '0, '0);

        // Address 50: in range for dut_a only; address 2 must be untouched.
        drive(1'b0, '0, 1'b1, 6'd50, W'(1), 4'hF);
        drive(1'b1, 6'd50, 1'b0, '0, '0, '0);
        drive(1'b1, 6'd2, 1'b0, '0, '0, '0);

        // Back-to-back reads of 0..9, then idle to observe hold.
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1, 6'(i), rand_word(), 4'hF);
        for (int i = 0; i < 10; i++) drive(1'b1, 6'(i), 1'b0, '0, '0, '0);
        drive_idle(4);

        // Random traffic with frequent same-address collisions.
        for (int n = 0; n < 400; n++) begin
            ra = 6'($urandom_range(0, 63));
            wa = ($urandom_range(0, 3) == 0) ? ra : 6'($urandom_range(0, 63));
            drive($urandom_range(0, 9) < 7, ra, $urandom_range(0, 9) < 6, wa,
                  rand_word(), 4'($urandom_range(0, 15)));
        end
        drive_idle(4);

        // Reset with a dut_a read still in flight: it must never appear.
        drive(1'b1, 6'd5, 1'b0, '0, '0, '0);
        @(negedge clk);
        set_idle();
        #2;
        rst_n = 1'b0;
        flush_sb();
        @(negedge clk);
        chk("a_flush_valid", W'(a_valid), '0);
        chk("a_flush_data",  a_data, '0);
        chk("b_flush_valid", W'(b_valid), '0);
        chk("b_flush_data",  b_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Interrupt the sweep at cycle 20 for two cycles.
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("a_busy_in_reset", W'(a_busy), W'(1'b1));
        chk("b_busy_in_reset", W'(b_busy), W'(1'b1));
        @(negedge clk);
        chk("a_busy_in_reset", W'(a_busy), W'(1'b1));
        chk("b_busy_in_reset", W'(b_busy), W'(1'b1));
        rst_n = 1'b1;
        measure_init(1'b0);
        clear_model();

        // Contents zeroed by the restarted sweep.
        drive(1'b1, 6'd5, 1'b0, '0, '0, '0);
        drive(1'b1, 6'd7, 1'b0, '0, '0, '0);
        drive(1'b1, 6'd47, 1'b0, '0, '0, '0);
        drive(1'b1, 6'd63, 1'b0, '0, '0, '0);
        drive_idle(5);

        chk("a_queue_drained", W'(exp_q_a.size()), '0);
        chk("b_queue_drained", W'(exp_q_b.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_array_1r1w_pipe.md
SRAM_ARRAY_1R1W_PIPE -- requirements
Module: sram_array_1r1w_pipe

Interface
REQ-001 Parameter DEPTH, default 64, number of words; legal range 2..4096, power of two not required.
REQ-002 Parameter WIDTH, default 256, bits per word.
REQ-003 Parameter MASK_GRAN, default 64, bits per write-mask segment; WIDTH SHALL be a multiple of MASK_GRAN; MASK_SEG = WIDTH/MASK_GRAN.
REQ-004 Parameter READ_LATENCY, default 1, cycles from R0_en to R0_valid; legal values 1 and 2.
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle same-address read returns newly written data, 0 = returns old data.
REQ-006 Parameter INIT_ON_RESET, default 1; 1 = zero-fill sweep after reset.
REQ-007 clock  in  1  sole clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 R0_addr  in  ADDR_W = max(1, clog2(DEPTH))  read address.
REQ-010 R0_en  in  1  read request.
REQ-011 R0_data  out  WIDTH  read data.
REQ-012 R0_valid  out  1  R0_data carries the result of a request.
REQ-013 W0_addr  in  ADDR_W  write address.
REQ-014 W0_en  in  1  write request.
REQ-015 W0_data  in  WIDTH  write data.
REQ-016 W0_mask  in  MASK_SEG  per-segment write enable; bit i covers bits [i*MASK_GRAN +: MASK_GRAN].
REQ-017 init_busy  out  1  zero-fill sweep in progress; requests ignored.

Function
REQ-018 FSM states INIT and IDLE; INIT entered on reset when INIT_ON_RESET=1, else IDLE.
REQ-019 INIT writes all-zero to address ptr each cycle, ptr counts 0..DEPTH-1, then IDLE; the sweep takes exactly DEPTH cycles after reset release.
REQ-020 init_busy SHALL be 1 exactly while in INIT; R0_en and W0_en are ignored in INIT, and R0_valid stays 0.
REQ-021 In IDLE, a write with W0_en=1 updates only segments with W0_mask=1; other segments keep their value.
REQ-022 A read accepted in cycle T presents its data with R0_valid=1 in cycle T+READ_LATENCY; one read accepted per cycle, fully pipelined.
REQ-023 Read data is sampled from the array in cycle T; writes in cycles after T do not affect it.
REQ-024 A read and a write to the same address in the same cycle with BYPASS=1 return a per-segment merge: masked-on segments from W0_data, others from the old word; with BYPASS=0 they return the old word.
REQ-025 When no read is delivered, R0_valid=0 and R0_data holds its last value; no random or garbage data.
REQ-026 An address >= DEPTH SHALL be a no-op for writes and SHALL return all-zero data, with R0_valid still asserted, for reads.
REQ-027 W0_mask all-zero with W0_en=1 leaves the array unchanged; a bypass read then returns the old word.

Reset
REQ-028 On reset assertion: R0_valid=0, R0_data=0, the read pipeline is flushed, and ptr=0; init_busy=1 if INIT_ON_RESET=1, else 0.
REQ-029 Array contents are not cleared by reset itself, only by the INIT sweep.
REQ-030 Reset asserted mid-sweep restarts the sweep at address 0; reset asserted with reads in flight discards them.

Structure
REQ-031 ADDR_W computation, FSM state enum and mask-merge function SHALL be in a shared package, sram_pkg.
REQ-032 A single sub-module, sram_rdpipe, SHALL implement the READ_LATENCY-deep data/valid pipeline; the storage array is inferred in the top.

Verification
REQ-033 INIT_ON_RESET=1, DEPTH=64: release reset -> init_busy=1 for 64 cycles; then a read of address 63 -> 0 with R0_valid=1.
REQ-034 Write addr 5 = 0xA5..A5 with mask all-ones, then read addr 5 at READ_LATENCY=2 -> R0_valid=1 two cycles after R0_en, R0_data=0xA5..A5.
REQ-035 Addr 7 = all-ones; write 0 with W0_mask=4'b0101 and a same-cycle read of 7 -> BYPASS=1: segments 1,3 = ones, segments 0,2 = 0; BYPASS=0: all-ones.
REQ-036 DEPTH=48: write addr 50 with data 0x1, then read addr 50 -> R0_data=0, R0_valid=1, and a read of addr 50 mod 48 = 2 is unchanged.
REQ-037 Assert reset at sweep cycle 20 for 2 cycles -> init_busy is held, and the sweep restarts with the full 64 cycles.
REQ-038 Back-to-back reads of addresses 0..9 each cycle -> 10 consecutive R0_valid pulses with data in order, and R0_data held after the last pulse.
